// File: rtl/dual_seg7_capture.sv
// Receive side of the two-digit seven-segment link: synchronizes both segment
// buses, waits for a stable pattern, decodes it to a byte and offers it on valid/ready.
module dual_seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_hi,
  input  logic [6:0] seg_lo,
  input  logic       out_ready,
  input  logic       clr_overrun,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_blank,
  output logic       out_error,
  output logic       overrun
);

  typedef enum logic [1:0] {
    TRACK  = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  // Returns {blank, error, nibble}; blank and illegal digits read as nibble 0.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    logic [5:0] res;
    case (seg)
      7'h3F:   res = {2'b00, 4'h0};
      7'h06:   res = {2'b00, 4'h1};
      7'h5B:   res = {2'b00, 4'h2};
      7'h4F:   res = {2'b00, 4'h3};
      7'h66:   res = {2'b00, 4'h4};
      7'h6D:   res = {2'b00, 4'h5};
      7'h7D:   res = {2'b00, 4'h6};
      7'h07:   res = {2'b00, 4'h7};
      7'h7F:   res = {2'b00, 4'h8};
      7'h6F:   res = {2'b00, 4'h9};
      7'h77:   res = {2'b00, 4'hA};
      7'h7C:   res = {2'b00, 4'hB};
      7'h39:   res = {2'b00, 4'hC};
      7'h5E:   res = {2'b00, 4'hD};
      7'h79:   res = {2'b00, 4'hE};
      7'h71:   res = {2'b00, 4'hF};
      7'h00:   res = {2'b10, 4'h0};
      default: res = {2'b01, 4'h0};
    endcase
    return res;
  endfunction

  logic [13:0] sync_r [SYNC_STAGES];
  logic [13:0] sample_r;
  logic [7:0]  cnt_r;
  logic [13:0] last_r;
  logic        last_vld_r;
  state_t      state_r;

  logic [13:0] sync_out_s;
  logic        same_s;
  logic        stable_evt_s;
  logic        is_last_s;
  logic        free_s;
  logic        ovr_evt_s;
  logic [5:0]  dec_hi_s;
  logic [5:0]  dec_lo_s;

  // Stability detection and overrun decision from the synchronized pattern.
  always_comb begin
    sync_out_s   = sync_r[SYNC_STAGES-1];
    same_s       = (sync_out_s == sample_r);
    stable_evt_s = same_s && (cnt_r == (STABLE_C - 8'd1));
    is_last_s    = last_vld_r && (last_r == sync_out_s);
    free_s       = !out_valid || out_ready;
    ovr_evt_s    = stable_evt_s && !is_last_s && !free_s;
    dec_hi_s     = seg_decode(sync_out_s[13:7]);
    dec_lo_s     = seg_decode(sync_out_s[6:0]);
  end

  // Input synchronizer chain for all fourteen segment lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 14'h0000;
    end else begin
      sync_r[0] <= {seg_hi, seg_lo};
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Previous-cycle sample and saturating stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_r <= 14'h0000;
      cnt_r    <= 8'd0;
    end else begin
      sample_r <= sync_out_s;
      if (!same_s) begin
        cnt_r <= 8'd0;
      end else if (cnt_r != STABLE_C) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Capture FSM with registered handshake outputs and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= TRACK;
      out_valid  <= 1'b0;
      out_byte   <= 8'h00;
      out_blank  <= 1'b0;
      out_error  <= 1'b0;
      overrun    <= 1'b0;
      last_r     <= 14'h0000;
      last_vld_r <= 1'b0;
    end else begin
      if (stable_evt_s && !is_last_s) begin
        // A dropped pattern leaves the pending output untouched.
        if (free_s) begin
          out_valid  <= 1'b1;
          out_byte   <= {dec_hi_s[3:0], dec_lo_s[3:0]};
          out_blank  <= dec_hi_s[5] | dec_lo_s[5];
          out_error  <= dec_hi_s[4] | dec_lo_s[4];
          last_r     <= sync_out_s;
          last_vld_r <= 1'b1;
        end else begin
          out_valid  <= out_valid;
        end
        state_r <= HOLD;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        state_r   <= TRACK;
      end else if ((state_r == TRACK) && !same_s) begin
        state_r <= SETTLE;
      end else if ((state_r == SETTLE) && stable_evt_s) begin
        state_r <= TRACK;
      end else begin
        state_r <= state_r;
      end

      if (ovr_evt_s) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule
